// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the ALU execute stage.
// Holds the 5-bit ALU control encoding, the mul/div sequencer states,
// the datapath width and a magnitude helper used when signed mul/div
// operands are accepted.
package alu_pkg;

  localparam int XLEN = 32;

  typedef enum logic [4:0] {
    OP_AND   = 5'b00000,
    OP_OR    = 5'b00001,
    OP_XOR   = 5'b00010,
    OP_ADD   = 5'b00011,
    OP_SUB   = 5'b00100,
    OP_SLTU  = 5'b00101,
    OP_SLT   = 5'b00110,
    OP_MULTU = 5'b00111,
    OP_MULT  = 5'b01000,
    OP_SLL   = 5'b01001,
    OP_SLLV  = 5'b01010,
    OP_SRA   = 5'b01011,
    OP_SRL   = 5'b01100,
    OP_SRAV  = 5'b01101,
    OP_SRLV  = 5'b01110,
    OP_DIV   = 5'b01111,
    OP_DIVU  = 5'b10000,
    OP_MTHI  = 5'b10001,
    OP_MTLO  = 5'b10010,
    OP_BLTZ  = 5'b10011,
    OP_BGTZ  = 5'b10100,
    OP_BGEZ  = 5'b10101,
    OP_BNE   = 5'b10110,
    OP_BLEZ  = 5'b10111,
    OP_PASSA = 5'b11000,
    OP_LUI   = 5'b11001,
    OP_MFHI  = 5'b11010,
    OP_MFLO  = 5'b11011,
    OP_REPB  = 5'b11100,
    OP_REPH  = 5'b11101,
    OP_ADDR  = 5'b11110,
    OP_NONE  = 5'b11111
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } muldiv_state_t;

  // Absolute value when the operand is treated as signed, else pass-through.
  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic is_signed);
    return (is_signed && v[XLEN-1]) ? -v : v;
  endfunction

endpackage

// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: iterative multiply/divide sequencer owning HI/LO.
// IDLE -> RUN (ITER_CYCLES steps) -> FINISH -> IDLE; HI/LO are written at
// the edge leaving FINISH and done pulses in the following IDLE cycle.
// Multiply is shift-add, divide is restoring; both work on magnitudes and
// the sign is applied in FINISH. One 64-bit work register is shared:
//   multiply: {partial product high, multiplier/low product}
//   divide:   {partial remainder, dividend/quotient}
// Optional macro ALU_FAST_MULT_EN: MULT/MULTU compute the full product at
// accept and jump straight to FINISH.
// Handshake: a request is taken on any edge where start=1 and the sequencer
// is IDLE; start while RUN/FINISH is dropped with no effect.
module alu_muldiv_seq
  import alu_pkg::*;
#(
  parameter int ITER_CYCLES = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  alu_op_t         op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output muldiv_state_t   state,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam logic [5:0] CNT_INIT = 6'(ITER_CYCLES - 1);

  muldiv_state_t state_q, state_d;
  logic [5:0]    cnt_q, cnt_d;
  logic [63:0]   work_q, work_d;
  logic [31:0]   opnd_q, opnd_d;
  logic          is_div_q, is_div_d;
  logic          neg_lo_q, neg_lo_d;
  logic          neg_hi_q, neg_hi_d;
  logic          div0_q, div0_d;
  logic          done_q, done_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;

  logic          op_signed;
  logic [31:0]   mag_a, mag_b;
  logic [32:0]   mul_sum;
  logic [63:0]   mul_next, div_next, prod_fix;
  logic          div_ge;
  logic [31:0]   div_diff, quot_fix, rem_fix;

  assign op_signed = (op == OP_MULT) || (op == OP_DIV);
  assign mag_a     = mag(a, op_signed);
  assign mag_b     = mag(b, op_signed);

  // One shift-add step: add multiplicand to the high half if LSB set, shift right.
  assign mul_sum  = {1'b0, work_q[63:32]} + (work_q[0] ? {1'b0, opnd_q} : 33'd0);
  assign mul_next = {mul_sum, work_q[31:1]};

  // One restoring step: shift next dividend bit into the remainder, subtract if it fits.
  assign div_ge   = work_q[63:31] >= {1'b0, opnd_q};
  assign div_diff = work_q[62:31] - opnd_q;
  assign div_next = div_ge ? {div_diff, work_q[30:0], 1'b1} : {work_q[62:0], 1'b0};

  // Sign correction applied in FINISH.
  assign prod_fix = neg_lo_q ? -work_q : work_q;
  assign quot_fix = neg_lo_q ? -work_q[31:0] : work_q[31:0];
  assign rem_fix  = neg_hi_q ? -work_q[63:32] : work_q[63:32];

  // Next-state, datapath step and HI/LO update.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    work_d   = work_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    div0_d   = div0_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          case (op)
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            OP_MULT, OP_MULTU: begin
              is_div_d = 1'b0;
              div0_d   = 1'b0;
              neg_lo_d = op_signed && (a[31] ^ b[31]);
              neg_hi_d = 1'b0;
`ifdef ALU_FAST_MULT_EN
              work_d   = {32'b0, mag_a} * {32'b0, mag_b};
              state_d  = FINISH;
`else
              work_d   = {32'b0, mag_b};
              opnd_d   = mag_a;
              cnt_d    = CNT_INIT;
              state_d  = RUN;
`endif
            end
            OP_DIV, OP_DIVU: begin
              is_div_d = 1'b1;
              div0_d   = (b == 32'b0);
              neg_lo_d = op_signed && (a[31] ^ b[31]);
              neg_hi_d = op_signed && a[31];
              work_d   = {32'b0, mag_a};
              opnd_d   = mag_b;
              cnt_d    = CNT_INIT;
              state_d  = (b == 32'b0) ? FINISH : RUN;
            end
            default: ;
          endcase
        end
      end
      RUN: begin
        work_d = is_div_q ? div_next : mul_next;
        cnt_d  = cnt_q - 6'd1;
        if (cnt_q == 6'd0) state_d = FINISH;
      end
      FINISH: begin
        if (!div0_q) begin
          if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quot_fix;
          end else begin
            hi_d = prod_fix[63:32];
            lo_d = prod_fix[31:0];
          end
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 6'd0;
      work_q   <= 64'd0;
      opnd_q   <= 32'd0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      div0_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      work_q   <= work_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      div0_q   <= div0_d;
      done_q   <= done_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign state = state_q;
  assign done  = done_q;
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: rtl/alu_execute.sv
// alu_execute: ALU execute stage. Combinational result/zero/cond for the
// single-cycle codes; MULT/MULTU/DIV/DIVU and MTHI/MTLO are handed to
// alu_muldiv_seq, which owns HI/LO. busy mirrors the sequencer state.
// Optional macro ALU_FAST_MULT_EN selects the single-cycle multiplier
// inside alu_muldiv_seq.
module alu_execute #(
  parameter int XLEN        = 32,
  parameter int ITER_CYCLES = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [4:0]      alucontrol,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [4:0]      shamt,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            cond,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);
  import alu_pkg::*;

  alu_op_t         op;
  muldiv_state_t   md_state;
  logic [XLEN-1:0] result_c;
  logic            cond_c;

  assign op = alu_op_t'(alucontrol);

  // Single-cycle result and branch condition; branch codes return {0, cond}.
  always_comb begin
    result_c = '0;
    cond_c   = 1'b0;
    case (op)
      OP_AND:   result_c = a & b;
      OP_OR:    result_c = a | b;
      OP_XOR:   result_c = a ^ b;
      OP_ADD:   result_c = a + b;
      OP_SUB: begin
        result_c = a - b;
        cond_c   = (a == b);
      end
      OP_SLTU:  result_c = {{(XLEN-1){1'b0}}, (a < b)};
      OP_SLT:   result_c = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLL:   result_c = b << shamt;
      OP_SLLV:  result_c = b << a[4:0];
      OP_SRA:   result_c = $unsigned($signed(b) >>> shamt);
      OP_SRL:   result_c = b >> shamt;
      OP_SRAV:  result_c = $unsigned($signed(b) >>> a[4:0]);
      OP_SRLV:  result_c = b >> a[4:0];
      OP_BLTZ:  cond_c = a[XLEN-1];
      OP_BGTZ:  cond_c = !a[XLEN-1] && (a != '0);
      OP_BGEZ:  cond_c = !a[XLEN-1];
      OP_BNE:   cond_c = (a != b);
      OP_BLEZ:  cond_c = a[XLEN-1] || (a == '0);
      OP_PASSA: result_c = a;
      OP_LUI:   result_c = {b[15:0], 16'h0000};
      OP_MFHI:  result_c = hi;
      OP_MFLO:  result_c = lo;
      OP_REPB:  result_c = {4{b[7:0]}};
      OP_REPH:  result_c = {2{b[15:0]}};
      OP_ADDR:  result_c = a + b;
      default:  result_c = '0;
    endcase
    if (op inside {OP_BLTZ, OP_BGTZ, OP_BGEZ, OP_BNE, OP_BLEZ})
      result_c = {{(XLEN-1){1'b0}}, cond_c};
  end

  alu_muldiv_seq #(
    .ITER_CYCLES (ITER_CYCLES)
  ) u_muldiv (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .state (md_state),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  assign result = result_c;
  assign zero   = (result_c == '0);
  assign cond   = cond_c;
  assign busy   = (md_state != IDLE);

endmodule

// File: tb/tb_alu_execute.sv
// tb_alu_execute: table-driven checks of the combinational codes plus
// hand-written mul/div, HI/LO access and reset-abort sequences.
module tb_alu_execute;

  localparam logic [4:0] C_AND = 5'b00000, C_OR = 5'b00001, C_XOR = 5'b00010, C_ADD = 5'b00011;
  localparam logic [4:0] C_SUB = 5'b00100, C_SLTU = 5'b00101, C_SLT = 5'b00110, C_MULTU = 5'b00111;
  localparam logic [4:0] C_MULT = 5'b01000, C_SLL = 5'b01001, C_SLLV = 5'b01010, C_SRA = 5'b01011;
  localparam logic [4:0] C_SRL = 5'b01100, C_SRAV = 5'b01101, C_SRLV = 5'b01110, C_DIV = 5'b01111;
  localparam logic [4:0] C_DIVU = 5'b10000, C_MTHI = 5'b10001, C_MTLO = 5'b10010, C_BLTZ = 5'b10011;
  localparam logic [4:0] C_BGTZ = 5'b10100, C_BGEZ = 5'b10101, C_BNE = 5'b10110, C_BLEZ = 5'b10111;
  localparam logic [4:0] C_PASSA = 5'b11000, C_LUI = 5'b11001, C_MFHI = 5'b11010, C_MFLO = 5'b11011;
  localparam logic [4:0] C_REPB = 5'b11100, C_REPH = 5'b11101, C_ADDR = 5'b11110, C_NONE = 5'b11111;

`ifdef ALU_FAST_MULT_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = 34;
`endif
  localparam int DIV_LAT = 34;

  logic        clk, reset, start;
  logic [4:0]  alucontrol, shamt;
  logic [31:0] a, b;
  logic [31:0] result, hi, lo;
  logic        zero, cond, busy, done;

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_q[$];
  logic [31:0] model_hi, model_lo;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [31:0] res;
    logic        cnd;
  } vec_t;
  vec_t vecs[$];

  alu_execute dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .alucontrol (alucontrol),
    .a          (a),
    .b          (b),
    .shamt      (shamt),
    .result     (result),
    .zero       (zero),
    .cond       (cond),
    .busy       (busy),
    .done       (done),
    .hi         (hi),
    .lo         (lo)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model for mul/div: returns {hi, lo}; divide by zero keeps old values.
  function automatic logic [63:0] md_model(input logic [4:0] op, input logic [31:0] x,
                                           input logic [31:0] y, input logic [31:0] ohi,
                                           input logic [31:0] olo);
    logic signed [63:0] px, py;
    logic signed [31:0] sx, sy;
    px = {{32{x[31]}}, x};
    py = {{32{y[31]}}, y};
    sx = x;
    sy = y;
    case (op)
      C_MULT:  return px * py;
      C_MULTU: return {32'b0, x} * {32'b0, y};
      C_DIV:   return (y == 0) ? {ohi, olo} : {$unsigned(sx % sy), $unsigned(sx / sy)};
      C_DIVU:  return (y == 0) ? {ohi, olo} : {x % y, x / y};
      default: return {ohi, olo};
    endcase
  endfunction

  // Issue one mul/div (caller is just past an edge), wait for done, compare.
  task automatic run_md(input logic [4:0] op, input logic [31:0] av, input logic [31:0] bv,
                        input int exp_lat, input string name);
    logic [63:0] expv;
    int lat;
    expv = md_model(op, av, bv, model_hi, model_lo);
    exp_q.push_back(expv);
    alucontrol = op; a = av; b = bv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, " done"}, {63'b0, done}, 64'd1);
    check({name, " latency"}, 64'(lat), 64'(exp_lat));
    check({name, " hi/lo"}, {hi, lo}, exp_q.pop_front());
    {model_hi, model_lo} = expv;
  endtask

  initial begin
    logic [63:0] got;
    logic [4:0]  rop;
    logic [31:0] ra, rb;
    int lat;
    logic seen_done;

    reset = 1'b1; start = 1'b0; alucontrol = C_NONE; a = '0; b = '0; shamt = '0;
    model_hi = '0; model_lo = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("reset hi", {32'b0, hi}, 64'd0);
    check("reset lo", {32'b0, lo}, 64'd0);
    check("reset busy", {63'b0, busy}, 64'd0);
    check("reset done", {63'b0, done}, 64'd0);
    reset = 1'b0;

    // Combinational vectors: {op, a, b, shamt, result, cond}.
    vecs.push_back('{C_SRA,   32'h0,        32'h80000000, 5'd4,  32'hF8000000, 1'b0});
    vecs.push_back('{C_SRLV,  32'd33,       32'h80000000, 5'd0,  32'h40000000, 1'b0});
    vecs.push_back('{C_SLT,   32'hFFFFFFFF, 32'h1,        5'd0,  32'h1,        1'b0});
    vecs.push_back('{C_SLTU,  32'hFFFFFFFF, 32'h1,        5'd0,  32'h0,        1'b0});
    vecs.push_back('{C_BGEZ,  32'h0,        32'h0,        5'd0,  32'h1,        1'b1});
    vecs.push_back('{C_BGTZ,  32'h0,        32'h0,        5'd0,  32'h0,        1'b0});
    vecs.push_back('{C_BLTZ,  32'h80000000, 32'h0,        5'd0,  32'h1,        1'b1});
    vecs.push_back('{C_BNE,   32'd5,        32'd5,        5'd0,  32'h0,        1'b0});
    vecs.push_back('{C_SUB,   32'd5,        32'd5,        5'd0,  32'h0,        1'b1});
    vecs.push_back('{C_SUB,   32'd5,        32'd7,        5'd0,  32'hFFFFFFFE, 1'b0});
    vecs.push_back('{C_AND,   32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'hF000F000, 1'b0});
    vecs.push_back('{C_OR,    32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'hFFF0FFF0, 1'b0});
    vecs.push_back('{C_XOR,   32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'h0FF00FF0, 1'b0});
    vecs.push_back('{C_ADD,   32'hFFFFFFFF, 32'h1,        5'd0,  32'h0,        1'b0});
    vecs.push_back('{C_SLL,   32'h0,        32'h1,        5'd31, 32'h80000000, 1'b0});
    vecs.push_back('{C_SLLV,  32'h24,       32'hF,        5'd0,  32'hF0,       1'b0});
    vecs.push_back('{C_SRL,   32'h0,        32'h80000000, 5'd31, 32'h1,        1'b0});
    vecs.push_back('{C_SRAV,  32'h1F,       32'h80000000, 5'd0,  32'hFFFFFFFF, 1'b0});
    vecs.push_back('{C_PASSA, 32'hDEADBEEF, 32'h0,        5'd0,  32'hDEADBEEF, 1'b0});
    vecs.push_back('{C_LUI,   32'h0,        32'h00001234, 5'd0,  32'h12340000, 1'b0});
    vecs.push_back('{C_REPB,  32'h0,        32'h000000AB, 5'd0,  32'hABABABAB, 1'b0});
    vecs.push_back('{C_REPH,  32'h0,        32'h0000BEEF, 5'd0,  32'hBEEFBEEF, 1'b0});
    vecs.push_back('{C_ADDR,  32'h1000,     32'hFFFFFFFC, 5'd0,  32'h00000FFC, 1'b0});
    vecs.push_back('{C_BLEZ,  32'hFFFFFFFF, 32'h0,        5'd0,  32'h1,        1'b1});
    vecs.push_back('{C_BLEZ,  32'h1,        32'h0,        5'd0,  32'h0,        1'b0});
    vecs.push_back('{C_BGTZ,  32'h7,        32'h0,        5'd0,  32'h1,        1'b1});
    vecs.push_back('{C_NONE,  32'd5,        32'd5,        5'd0,  32'h0,        1'b0});
    vecs.push_back('{C_MULTU, 32'd5,        32'd5,        5'd0,  32'h0,        1'b0});

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk); #1;
      alucontrol = vecs[i].op; a = vecs[i].a; b = vecs[i].b; shamt = vecs[i].sh;
      exp_q.push_back({31'b0, vecs[i].cnd, vecs[i].res});
      #3;
      got = exp_q.pop_front();
      check($sformatf("vec%0d result", i), {32'b0, result}, {32'b0, got[31:0]});
      check($sformatf("vec%0d cond", i), {63'b0, cond}, {63'b0, got[32]});
      check($sformatf("vec%0d zero", i), {63'b0, zero}, {63'b0, (got[31:0] == 32'b0)});
    end
    @(posedge clk); #1;

    // Directed multiply/divide, issued back to back (done cycle accepts next start).
    run_md(C_MULT, 32'hFFFFFFFF, 32'h2, MUL_LAT, "mult");
    check("mult const", {hi, lo}, 64'hFFFFFFFF_FFFFFFFE);
    run_md(C_MULTU, 32'hFFFFFFFF, 32'h2, MUL_LAT, "multu");
    check("multu const", {hi, lo}, 64'h00000001_FFFFFFFE);
    run_md(C_DIV, 32'hFFFFFFF9, 32'h2, DIV_LAT, "div");
    check("div const", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    run_md(C_DIVU, 32'd100, 32'd0, 2, "divu by zero");
    check("divu0 const", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    @(posedge clk); #1;
    check("done single pulse", {63'b0, done}, 64'd0);

    // Random multiply/divide.
    for (int i = 0; i < 8; i++) begin
      case ($urandom_range(0, 3))
        0: rop = C_MULT;
        1: rop = C_MULTU;
        2: rop = C_DIV;
        default: rop = C_DIVU;
      endcase
      ra = $urandom;
      rb = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 255)) : $urandom;
      if (rb == 32'b0) rb = 32'd3;
      if (rop == C_DIV && ra == 32'h80000000 && rb == 32'hFFFFFFFF) rb = 32'd3;
      run_md(rop, ra, rb, (rop == C_MULT || rop == C_MULTU) ? MUL_LAT : DIV_LAT,
             $sformatf("rand%0d", i));
    end

    // MTHI while busy is dropped; MFLO while busy reads the old LO.
    alucontrol = C_DIVU; a = 32'd1000; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    alucontrol = C_MTHI; a = 32'h12345678;
    @(posedge clk); #1;
    start = 1'b0;
    check("mthi busy ignored", {32'b0, hi}, {32'b0, model_hi});
    check("busy during div", {63'b0, busy}, 64'd1);
    alucontrol = C_MFLO;
    #1;
    check("mflo while busy", {32'b0, result}, {32'b0, model_lo});
    lat = 2;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("divu2 done", {63'b0, done}, 64'd1);
    check("divu2 latency", 64'(lat), 64'(DIV_LAT));
    check("divu2 hi/lo", {hi, lo}, {32'd6, 32'd142});

    // MTHI/MTLO once idle, read back through MFHI/MFLO.
    alucontrol = C_MTHI; a = 32'h12345678; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; alucontrol = C_MFHI;
    #1;
    check("mfhi after mthi", {32'b0, result}, 64'h12345678);
    check("hi after mthi", {32'b0, hi}, 64'h12345678);
    @(posedge clk); #1;
    alucontrol = C_MTLO; a = 32'hCAFEF00D; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; alucontrol = C_MFLO;
    #1;
    check("mflo after mtlo", {32'b0, result}, 64'hCAFEF00D);

    // Reset in RUN cycle 10 of a DIV aborts it and clears HI/LO at once.
    @(posedge clk); #1;
    alucontrol = C_DIV; a = 32'hFFFFFFF9; b = 32'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    check("busy before reset", {63'b0, busy}, 64'd1);
    reset = 1'b1;
    #1;
    check("abort busy", {63'b0, busy}, 64'd0);
    check("abort done", {63'b0, done}, 64'd0);
    check("abort hi/lo", {hi, lo}, 64'd0);
    #2;
    reset = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) seen_done = 1'b1;
    end
    check("no done after abort", {63'b0, seen_done}, 64'd0);
    model_hi = '0; model_lo = '0;
    run_md(C_MULTU, 32'd3, 32'd5, MUL_LAT, "multu after reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
